// File: rtl/reg_file_wb_pkg.sv
// Shared widths, reset polarity and the EX/WB entry type for the write-back register file.
// Optional macro REGFILE_BYPASS_EN (used by reg_file_wb) enables EX/WB forwarding on reads.
package reg_file_wb_pkg;

  localparam int REG_LENGTH   = 32;
  localparam int REG_ADDR_LEN = 5;
  localparam int REG_NUM      = 2 ** REG_ADDR_LEN;

  localparam logic ENABLE     = 1'b1;
  localparam logic DISABLE    = 1'b0;
  localparam logic RST_ACTIVE = 1'b0;

  typedef struct packed {
    logic                    wr;
    logic [REG_ADDR_LEN-1:0] addr;
    logic [REG_LENGTH-1:0]   data;
  } wb_entry_t;

  function automatic logic is_zero_reg(input logic [REG_ADDR_LEN-1:0] addr);
    return addr == '0;
  endfunction

endpackage

// File: rtl/reg_file_wb_reg_array.sv
// reg_array: REG_NUM x REG_LENGTH storage, one synchronous write port, two asynchronous
// read ports, asynchronous clear; register $0 is never written and always reads zero.
module reg_file_wb_reg_array
  import reg_file_wb_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [REG_ADDR_LEN-1:0] waddr,
  input  logic [REG_LENGTH-1:0]   wdata,
  input  logic [REG_ADDR_LEN-1:0] raddr_a,
  output logic [REG_LENGTH-1:0]   rdata_a,
  input  logic [REG_ADDR_LEN-1:0] raddr_b,
  output logic [REG_LENGTH-1:0]   rdata_b
);

  logic [REG_LENGTH-1:0] mem_q [REG_NUM];

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      for (int i = 0; i < REG_NUM; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we == ENABLE && !is_zero_reg(waddr)) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata_a = is_zero_reg(raddr_a) ? '0 : mem_q[raddr_a];
  assign rdata_b = is_zero_reg(raddr_b) ? '0 : mem_q[raddr_b];

endmodule

// File: rtl/reg_file_wb.sv
// Write-back stage: EX/WB latch in front of a 32-entry register file with two combinational read ports.
// Define REGFILE_BYPASS_EN to forward EX and WB results to the read ports (EX has priority).
module reg_file_wb
  import reg_file_wb_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    regcWr,
  input  logic [REG_ADDR_LEN-1:0] regcAddr,
  input  logic [REG_LENGTH-1:0]   regcData,
  input  logic                    regaRd,
  input  logic [REG_ADDR_LEN-1:0] regaAddr,
  output logic [REG_LENGTH-1:0]   regaData,
  input  logic                    regbRd,
  input  logic [REG_ADDR_LEN-1:0] regbAddr,
  output logic [REG_LENGTH-1:0]   regbData,
  output logic                    wbWr,
  output logic [REG_ADDR_LEN-1:0] wbAddr,
  output logic [REG_LENGTH-1:0]   wbData
);

  wb_entry_t             wb_q;
  wb_entry_t             wb_d;
  logic [REG_LENGTH-1:0] arr_a;
  logic [REG_LENGTH-1:0] arr_b;

  always_comb begin
    wb_d      = '0;
    wb_d.wr   = regcWr;
    wb_d.addr = regcAddr;
    wb_d.data = regcData;
  end

  // Reset drops the pending entry, so it never reaches the array.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ACTIVE) begin
      wb_q <= '0;
    end else begin
      wb_q <= wb_d;
    end
  end

  assign wbWr   = wb_q.wr;
  assign wbAddr = wb_q.addr;
  assign wbData = wb_q.data;

  reg_file_wb_reg_array u_reg_array (
    .clk     (clk),
    .rst     (rst),
    .we      (wb_q.wr),
    .waddr   (wb_q.addr),
    .wdata   (wb_q.data),
    .raddr_a (regaAddr),
    .rdata_a (arr_a),
    .raddr_b (regbAddr),
    .rdata_b (arr_b)
  );

  function automatic logic [REG_LENGTH-1:0] read_sel(
    input logic                    rd,
    input logic [REG_ADDR_LEN-1:0] addr,
    input logic [REG_LENGTH-1:0]   arr
  );
    logic [REG_LENGTH-1:0] val;
    val = '0;
    // Gate on rst too: the EX forward path would otherwise leak regcData during reset.
    if (rst != RST_ACTIVE && rd == ENABLE && !is_zero_reg(addr)) begin
`ifdef REGFILE_BYPASS_EN
      if (regcWr == ENABLE && regcAddr == addr) begin
        val = regcData;
      end else if (wb_q.wr == ENABLE && wb_q.addr == addr) begin
        val = wb_q.data;
      end else begin
        val = arr;
      end
`else
      val = arr;
`endif
    end
    return val;
  endfunction

  always_comb begin
    regaData = read_sel(regaRd, regaAddr, arr_a);
    regbData = read_sel(regbRd, regbAddr, arr_b);
  end

endmodule
